time_field_counter: RTL
=======================

# time_field_counter

Parametrised two-digit BCD time-field counter for the alarm clock: one instance holds a complete field (minutes 00–59, hours 00–23 or 01–12) as tens and ones digits. It supports direct set, single-step increment and decrement with wrap-around, and registered carry/borrow pulses for cascading into the next field. It replaces the per-digit minute/hour registers and their hand-built wrap logic in the timekeeping and alarm-set paths.

## Interface
- MODULUS, 60: number of distinct field values; legal range 2..100.
- MIN_VAL, 0: lowest field value; the field counts MIN_VAL..MIN_VAL+MODULUS-1, which must be ≤ 99 (e.g. 1 with MODULUS 12 for 12-hour hours).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- set  in  1  load set_tens/set_ones this cycle.
- set_tens  in  4  BCD tens digit to load.
- set_ones  in  4  BCD ones digit to load.
- inc  in  1  step up by one.
- dec  in  1  step down by one (TIME_FIELD_DEC_EN only).
- tens  out  4  registered BCD tens digit.
- ones  out  4  registered BCD ones digit.
- carry  out  1  registered one-cycle pulse: an inc wrapped MAX→MIN.
- borrow  out  1  registered one-cycle pulse: a dec wrapped MIN→MAX.
- at_max  out  1  combinational: value == MAX (MIN_VAL+MODULUS-1).
- at_min  out  1  combinational: value == MIN_VAL.
- set_err  out  1  registered one-cycle pulse: a set was rejected.

## Operation
- Reset: tens/ones = BCD(MIN_VAL); carry, borrow and set_err = 0. Assertion mid-operation overrides everything immediately.
- Priority per cycle: set, then inc/dec.
- Set: accepted only if both digits are ≤ 9 and the decimal value is in [MIN_VAL, MAX]. On acceptance, load the value with no carry or borrow. On rejection, hold the value and pulse set_err. inc/dec are ignored in any cycle where set is high, accepted or not.
- inc alone:
  - value == MAX → load MIN_VAL and pulse carry.
  - otherwise, if ones == 9 → ones = 0, tens + 1.
  - otherwise → ones + 1.
- dec alone: the mirror of inc.
  - value == MIN_VAL → load MAX and pulse borrow.
  - otherwise, if ones == 0 → ones = 9, tens − 1.
  - otherwise → ones − 1.
- inc and dec together: hold the value, no pulses.
- Held inc or dec: steps once per cycle. Each wrap produces its own pulse.
- Digits never leave the BCD range 0..9, and the value never leaves [MIN_VAL, MAX].
- MAX digits are computed at elaboration time: (MAX/10, MAX%10).

## Timing
- All state updates on the rising edge of clk. Value latency is one cycle from a sampled inc/dec/set.
- carry, borrow and set_err assert in the same cycle as the resulting value is first visible. Each lasts exactly one cycle unless re-triggered.
- at_max and at_min follow the registered value with no extra latency. A cascaded next field may use `carry` directly as its `inc`.
- No handshake: every input is sampled every cycle.

## Configuration
- TIME_FIELD_DEC_EN defined:
  - dec is functional and borrow is generated as described.
- TIME_FIELD_DEC_EN undefined:
  - dec is ignored, so inc with dec high behaves as inc alone.
  - borrow is tied to 0.
  - the decrement and borrow logic is not built.

## Structure
- Shared package time_pkg holds:
  - bcd_t (4-bit digit) typedef.
  - BCD_MAX_DIGIT = 9 constant.
  - field-preset constants: MIN_MODULUS=60, HR24_MODULUS=24, HR12_MODULUS=12, HR12_MIN=1.
  - to_bcd_tens / to_bcd_ones elaboration-time functions.
- Sub-module bcd_digit_cell: one 4-bit BCD digit with step-up, step-down, load and wrap outputs (wraps_up at 9, wraps_down at 0). Instantiated twice; the field-level MAX/MIN wrap logic lives in time_field_counter.

## Test plan
- Reset, then MODULUS=60, MIN_VAL=0 and 60 inc pulses → 00,01..59,00. carry is high only in the cycle showing 00. at_max is high only at 59.
- MODULUS=12, MIN_VAL=1: after reset, read 01. set to 12, then inc → 01 with carry. dec → 12 with borrow (DEC_EN).
- MODULUS=24: set 23 → accepted. set 24 → set_err pulse, value stays 23. set_ones=4'hA → set_err.
- Value 09 with inc → 10. dec at 10 → 09. inc and dec together at 37 → stays 37 with no pulses. set with inc high → set value wins.
- Assert reset during a held inc at 45 → immediately 00 with all pulses low. On release, counting resumes from 00.
- Build without TIME_FIELD_DEC_EN: dec alone at 00 → 00 with borrow 0. inc with dec high → +1.

Source files
------------

// File: rtl/time_pkg.sv
// Shared definitions for the alarm-clock time fields: BCD digit type,
// field presets and elaboration-time helpers that split a decimal value
// into its BCD tens and ones digits.
package time_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DIGIT = 4'd9;

  // Field presets: minutes, 24-hour hours, 12-hour hours.
  localparam int MIN_MODULUS  = 60;
  localparam int HR24_MODULUS = 24;
  localparam int HR12_MODULUS = 12;
  localparam int HR12_MIN     = 1;

  function automatic bcd_t to_bcd_tens(input int value);
    return bcd_t'((value / 10) % 10);
  endfunction

  function automatic bcd_t to_bcd_ones(input int value);
    return bcd_t'(value % 10);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One registered BCD digit. Load has priority over step-up, which has
// priority over step-down. Stepping wraps 9->0 upward and 0->9 downward;
// wraps_up / wraps_down flag the digit values at which a step would wrap.
module bcd_digit_cell
  import time_pkg::*;
#(
  parameter bcd_t RESET_VAL = 4'd0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t load_val,
  input  logic up,
  input  logic down,
  output bcd_t value,
  output logic wraps_up,
  output logic wraps_down
);

  assign wraps_up   = (value == BCD_MAX_DIGIT);
  assign wraps_down = (value == 4'd0);

  // Digit register: load, then step up, then step down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (up) begin
      value <= wraps_up ? 4'd0 : value + 4'd1;
    end else if (down) begin
      value <= wraps_down ? BCD_MAX_DIGIT : value - 4'd1;
    end
  end

endmodule

// File: rtl/time_field_counter.sv
// Two-digit BCD time field (tens:ones) counting MIN_VAL..MIN_VAL+MODULUS-1.
// Supports checked direct set, increment with carry and, when the macro
// TIME_FIELD_DEC_EN is defined, decrement with borrow. Priority per cycle
// is set first, then inc/dec. carry/borrow/set_err are one-cycle pulses
// registered alongside the value they describe, so a following field can
// take carry straight into its inc.
module time_field_counter
  import time_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int MIN_VAL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  bcd_t set_tens,
  input  bcd_t set_ones,
  input  logic inc,
  input  logic dec,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry,
  output logic borrow,
  output logic at_max,
  output logic at_min,
  output logic set_err
);

  localparam int   MAX_VAL  = MIN_VAL + MODULUS - 1;
  localparam bcd_t MIN_TENS = to_bcd_tens(MIN_VAL);
  localparam bcd_t MIN_ONES = to_bcd_ones(MIN_VAL);
  localparam bcd_t MAX_TENS = to_bcd_tens(MAX_VAL);
  localparam bcd_t MAX_ONES = to_bcd_ones(MAX_VAL);
  localparam logic [7:0] MIN_V8 = 8'(MIN_VAL);
  localparam logic [7:0] MAX_V8 = 8'(MAX_VAL);

  logic       dec_req;
  logic [7:0] set_val;
  logic       set_ok;
  logic       step_up;
  logic       step_down;
  logic       wrap_up;
  logic       wrap_down;
  logic       digit_load;
  bcd_t       tens_load_val;
  bcd_t       ones_load_val;
  logic       ones_up;
  logic       ones_down;
  logic       tens_up;
  logic       tens_down;
  logic       ones_wraps_up;
  logic       ones_wraps_down;
  logic       unused_tens_wraps_up;
  logic       unused_tens_wraps_down;

`ifdef TIME_FIELD_DEC_EN
  assign dec_req = dec;
`else
  // Decrement is not part of this build; dec is accepted but ignored.
  logic unused_dec;
  assign unused_dec = dec;
  assign dec_req    = 1'b0;
`endif

  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign at_min = (tens == MIN_TENS) && (ones == MIN_ONES);

  // Set validation and per-digit step/load control for this cycle.
  always_comb begin
    set_val = 8'(set_tens) * 8'd10 + 8'(set_ones);
    set_ok  = set && (set_tens <= BCD_MAX_DIGIT) && (set_ones <= BCD_MAX_DIGIT)
              && (set_val >= MIN_V8) && (set_val <= MAX_V8);
    // inc and dec together cancel; any set (even rejected) blocks stepping.
    step_up   = !set && inc && !dec_req;
    step_down = !set && dec_req && !inc;
    wrap_up   = step_up && at_max;
    wrap_down = step_down && at_min;
    digit_load = set_ok || wrap_up || wrap_down;
    if (set_ok) begin
      tens_load_val = set_tens;
      ones_load_val = set_ones;
    end else if (wrap_up) begin
      tens_load_val = MIN_TENS;
      ones_load_val = MIN_ONES;
    end else begin
      tens_load_val = MAX_TENS;
      ones_load_val = MAX_ONES;
    end
    ones_up   = step_up && !at_max;
    ones_down = step_down && !at_min;
    tens_up   = ones_up && ones_wraps_up;
    tens_down = ones_down && ones_wraps_down;
  end

  bcd_digit_cell #(.RESET_VAL(MIN_ONES)) u_ones (
    .clk        (clk),
    .reset      (reset),
    .load       (digit_load),
    .load_val   (ones_load_val),
    .up         (ones_up),
    .down       (ones_down),
    .value      (ones),
    .wraps_up   (ones_wraps_up),
    .wraps_down (ones_wraps_down)
  );

  bcd_digit_cell #(.RESET_VAL(MIN_TENS)) u_tens (
    .clk        (clk),
    .reset      (reset),
    .load       (digit_load),
    .load_val   (tens_load_val),
    .up         (tens_up),
    .down       (tens_down),
    .value      (tens),
    .wraps_up   (unused_tens_wraps_up),
    .wraps_down (unused_tens_wraps_down)
  );

  // Carry and set-error pulses, aligned with the value they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry   <= 1'b0;
      set_err <= 1'b0;
    end else begin
      carry   <= wrap_up;
      set_err <= set && !set_ok;
    end
  end

`ifdef TIME_FIELD_DEC_EN
  // Borrow pulse, aligned with the MIN->MAX wrapped value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      borrow <= 1'b0;
    end else begin
      borrow <= wrap_down;
    end
  end
`else
  assign borrow = 1'b0;
`endif

endmodule
